// File: rtl/pll_mdrp_pkg.sv
// Shared opcodes and controller state encoding for the PLL modulation-port master.
package pll_mdrp_pkg;

   localparam logic [1:0] OPC_NOP = 2'b00;
   localparam logic [1:0] OPC_WR  = 2'b01;
   localparam logic [1:0] OPC_RD  = 2'b10;
   localparam logic [1:0] OPC_RST = 2'b11;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RST_PTR = 3'd1,
      INC     = 3'd2,
      ACCESS  = 3'd3,
      RD_WAIT = 3'd4,
      DONE    = 3'd5
   } state_t;

endpackage

// File: rtl/pll_mdclk_gen.sv
// Free-running modulation clock: toggles every CLK_DIV clk cycles.
// The rise/fall strobes are high in the clk cycle whose closing edge
// flips mdclk, so logic clocked by that edge changes together with mdclk.
module pll_mdclk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic resetn,
   output logic mdclk,
   output logic rise,
   output logic fall
);

   localparam int            CW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_r;
   logic          mdclk_r;
   logic          wrap_s;

   assign wrap_s = (cnt_r == CNT_LAST);
   assign rise   = wrap_s & ~mdclk_r;
   assign fall   = wrap_s &  mdclk_r;
   assign mdclk  = mdclk_r;

   // Half-period counter; mdclk flips each time the counter wraps.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_r   <= '0;
         mdclk_r <= 1'b0;
      end else if (wrap_s) begin
         cnt_r   <= '0;
         mdclk_r <= ~mdclk_r;
      end else begin
         cnt_r   <= cnt_r + 1'b1;
      end
   end

endmodule

// File: rtl/pll_mdrp_ctrl.sv
// Single-byte register access master for the PLL modulation port.
// Translates each request into pointer-reset / increment / access steps,
// one step per mdclk period, with all step outputs updated on mdclk falls.
module pll_mdrp_ctrl
   import pll_mdrp_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int ADDR_W  = 7
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [7:0]        req_wdata,
   output logic              resp_valid,
   output logic [7:0]        resp_rdata,
   output logic              busy,
   output logic              mdclk,
   output logic [1:0]        mdopc,
   output logic              mdainc,
   output logic [7:0]        mdwdi,
   input  logic [7:0]        mdrdo
);

   state_t            state_r;
   logic [ADDR_W-1:0] ptr_r;
   logic              ptr_valid_r;
   logic [ADDR_W-1:0] addr_r;
   logic              write_r;
   logic [7:0]        wdata_r;
   logic              start_r;
   logic              ready_r;
   logic              busy_r;
   logic              resp_valid_r;
   logic [7:0]        rdata_r;
   logic [1:0]        mdopc_r;
   logic              mdainc_r;
   logic [7:0]        mdwdi_r;

   logic              fall_s;
   logic              rise_unused_s;
   logic              accept_s;
   logic              need_rst_s;

   pll_mdclk_gen #(.CLK_DIV(CLK_DIV)) u_mdclk_gen (
      .clk    (clk),
      .resetn (resetn),
      .mdclk  (mdclk),
      .rise   (rise_unused_s),
      .fall   (fall_s)
   );

   assign accept_s   = req_valid && ready_r;
   assign need_rst_s = !ptr_valid_r || (addr_r < ptr_r);

   assign req_ready  = ready_r;
   assign busy       = busy_r;
   assign resp_valid = resp_valid_r;
   assign resp_rdata = rdata_r;
   assign mdopc      = mdopc_r;
   assign mdainc     = mdainc_r;
   assign mdwdi      = mdwdi_r;

   // Request acceptance and step sequencing; steps advance only on mdclk falls.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r      <= IDLE;
         ptr_r        <= '0;
         ptr_valid_r  <= 1'b0;
         addr_r       <= '0;
         write_r      <= 1'b0;
         wdata_r      <= 8'h00;
         start_r      <= 1'b0;
         ready_r      <= 1'b1;
         busy_r       <= 1'b0;
         resp_valid_r <= 1'b0;
         rdata_r      <= 8'h00;
         mdopc_r      <= OPC_NOP;
         mdainc_r     <= 1'b0;
         mdwdi_r      <= 8'h00;
      end else begin
         resp_valid_r <= 1'b0;

         // Only reachable in IDLE or in the DONE cycle, where ready_r is high.
         if (accept_s) begin
            addr_r  <= req_addr;
            write_r <= req_write;
            wdata_r <= req_wdata;
            start_r <= 1'b1;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
         end

         case (state_r)
            IDLE: begin
               if (start_r && fall_s) begin
                  start_r <= 1'b0;
                  if (need_rst_s) begin
                     state_r     <= RST_PTR;
                     mdopc_r     <= OPC_RST;
                     mdainc_r    <= 1'b0;
                     ptr_r       <= '0;
                     ptr_valid_r <= 1'b1;
                  end else if (addr_r != ptr_r) begin
                     state_r  <= INC;
                     mdopc_r  <= OPC_NOP;
                     mdainc_r <= 1'b1;
                     ptr_r    <= ptr_r + 1'b1;
                  end else begin
                     state_r  <= ACCESS;
                     mdopc_r  <= write_r ? OPC_WR : OPC_RD;
                     mdainc_r <= 1'b0;
                     mdwdi_r  <= write_r ? wdata_r : mdwdi_r;
                  end
               end
            end
            // ptr_r already reflects the pointer after the current step.
            RST_PTR, INC: begin
               if (fall_s) begin
                  if (addr_r != ptr_r) begin
                     state_r  <= INC;
                     mdopc_r  <= OPC_NOP;
                     mdainc_r <= 1'b1;
                     ptr_r    <= ptr_r + 1'b1;
                  end else begin
                     state_r  <= ACCESS;
                     mdopc_r  <= write_r ? OPC_WR : OPC_RD;
                     mdainc_r <= 1'b0;
                     mdwdi_r  <= write_r ? wdata_r : mdwdi_r;
                  end
               end
            end
            ACCESS: begin
               if (fall_s) begin
                  mdopc_r  <= OPC_NOP;
                  mdainc_r <= 1'b0;
                  if (write_r) begin
                     state_r      <= DONE;
                     resp_valid_r <= 1'b1;
                     ready_r      <= 1'b1;
                     busy_r       <= 1'b0;
                  end else begin
                     state_r      <= RD_WAIT;
                  end
               end
            end
            // The PLL has had a full step to present read data.
            RD_WAIT: begin
               if (fall_s) begin
                  rdata_r      <= mdrdo;
                  state_r      <= DONE;
                  resp_valid_r <= 1'b1;
                  ready_r      <= 1'b1;
                  busy_r       <= 1'b0;
               end
            end
            DONE: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
